// File: rtl/multi_cycle_control.sv
// multi_cycle_control: MIPS-style multi-cycle datapath controller.
// Moore outputs decoded from state; BRANCH pc_we follows zero.
module multi_cycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alu_ctl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t     cur;
    state_t     nxt;
    logic       f_ok;
    logic [2:0] f_ctl;
    logic       op_ok;

    always_comb begin
        f_ok  = 1'b1;
        f_ctl = 3'b000;
        case (funct)
            6'h20:   f_ctl = 3'b010;
            6'h22:   f_ctl = 3'b110;
            6'h24:   f_ctl = 3'b000;
            6'h25:   f_ctl = 3'b001;
            6'h2A:   f_ctl = 3'b111;
            6'h00:   f_ctl = 3'b011;
            default: f_ok  = 1'b0;
        endcase
    end

    always_comb begin
        op_ok = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
            OP_R:    op_ok = f_ok;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = DECODE;
            DECODE: begin
                if (op_ok) begin
                    case (opcode)
                        OP_LW, OP_SW: nxt = MEMADR;
                        OP_R:         nxt = EXEC;
                        OP_BEQ:       nxt = BRANCH;
                        OP_ADDI:      nxt = ADDIEX;
                        OP_J:         nxt = JUMP;
                        default:      nxt = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                if (opcode == OP_LW)      nxt = MEMRD;
                else if (opcode == OP_SW) nxt = MEMWR;
            end
            MEMRD:   nxt = MEMWB;
            EXEC:    nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) cur <= FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        alu_ctl    = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                mem_read  = 1'b1;
                ir_we     = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl   = 3'b010;
                pc_we     = 1'b1;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl   = 3'b010;
                illegal   = !op_ok;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctl   = 3'b010;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_ctl   = f_ctl;
            end
            ALUWB: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctl   = 3'b110;
                pc_src    = 2'b01;
                pc_we     = zero;
            end
            ADDIWB:  reg_we = 1'b1;
            JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
        // Held in reset: FETCH selects, but no strobe may fire.
        if (!rst) begin
            alu_ctl    = 3'b010;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_src     = 2'b00;
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            illegal    = 1'b0;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: vector table, reset corner and random
// instruction streams checked against a per-instruction model.
module tb_multi_cycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_we, ir_we, reg_we, mem_read, mem_write;
    logic       iord, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    multi_cycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .alu_ctl(alu_ctl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_we(pc_we),
        .ir_we(ir_we), .reg_we(reg_we), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state)
    );

    typedef struct packed {
        logic [2:0] alu_ctl;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_we;
        logic       ir_we;
        logic       reg_we;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       m2r;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        int          len;
        logic [23:0] seq;
    } vec_t;

    outs_t act;
    assign act = '{alu_ctl, alu_src_a, alu_src_b, pc_src, pc_we,
                   ir_we, reg_we, mem_read, mem_write, iord,
                   reg_dst, mem_to_reg, illegal};

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h",
                      name, $time, a, e);
    endtask

    function automatic logic legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    endfunction

    function automatic logic [2:0] fn_ctl(input logic [5:0] fn);
        case (fn)
            6'h20:   return 3'b010;
            6'h22:   return 3'b110;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            6'h00:   return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] op,
                                   input logic [5:0] fn);
        if (op == 6'h00) return legal_fn(fn);
        return op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    endfunction

    // Instruction-level model: the state walk each instruction takes.
    function automatic void model(input logic [5:0] op,
                                  input logic [5:0] fn,
                                  output int len,
                                  output logic [23:0] seq);
        int s[$];
        s = '{0, 1};
        if (legal(op, fn)) begin
            case (op)
                6'h23:   s = '{0, 1, 2, 3, 4};
                6'h2B:   s = '{0, 1, 2, 5};
                6'h00:   s = '{0, 1, 6, 7};
                6'h04:   s = '{0, 1, 8};
                6'h08:   s = '{0, 1, 9, 10};
                default: s = '{0, 1, 11};
            endcase
        end
        len = s.size();
        seq = '0;
        foreach (s[i]) seq[4*i +: 4] = 4'(s[i]);
    endfunction

    function automatic outs_t exp_out(input logic [3:0] st,
                                      input logic [5:0] op,
                                      input logic [5:0] fn,
                                      input logic z);
        outs_t o = '0;
        case (st)
            4'd0: begin
                o.alu_ctl = 3'b010; o.src_b = 2'b01; o.pc_we = 1;
                o.ir_we = 1; o.mem_read = 1;
            end
            4'd1: begin
                o.alu_ctl = 3'b010; o.src_b = 2'b11;
                o.illegal = !legal(op, fn);
            end
            4'd2, 4'd9: begin
                o.alu_ctl = 3'b010; o.src_a = 1; o.src_b = 2'b10;
            end
            4'd3:  begin o.mem_read = 1; o.iord = 1; end
            4'd4:  begin o.reg_we = 1; o.m2r = 1; end
            4'd5:  begin o.mem_write = 1; o.iord = 1; end
            4'd6:  begin o.alu_ctl = fn_ctl(fn); o.src_a = 1; end
            4'd7:  begin o.reg_we = 1; o.reg_dst = 1; end
            4'd8: begin
                o.alu_ctl = 3'b110; o.src_a = 1; o.pc_src = 2'b01;
                o.pc_we = z;
            end
            4'd10: o.reg_we = 1;
            4'd11: begin o.pc_src = 2'b10; o.pc_we = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t rst_out();
        outs_t o = '0;
        o.alu_ctl = 3'b010;
        o.src_b   = 2'b01;
        return o;
    endfunction

    // Entered at the FETCH-cycle negedge; leaves at the next one.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int len,
                             input logic [23:0] seq, input int stop);
        logic [3:0] es;
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                opcode = op; funct = fn; zero = z;
            end
            #1;
            es = seq[4*i +: 4];
            chk($sformatf("state op%h fn%h i%0d", op, fn, i),
                32'(state), 32'(es));
            chk($sformatf("outs op%h fn%h st%0d", op, fn, es),
                32'(act), 32'(exp_out(es, op, fn, z)));
            if (stop > 0 && i + 1 == stop) return;
        end
        @(negedge clk);
    endtask

    vec_t vt[14];

    initial begin
        int          len;
        logic [23:0] seq;
        logic [5:0]  op, fn;
        logic [5:0]  fl[6];

        vt[0]  = '{6'h23, 6'h00, 1'b0, 5, 24'h043210};
        vt[1]  = '{6'h00, 6'h2A, 1'b0, 4, 24'h007610};
        vt[2]  = '{6'h00, 6'h20, 1'b1, 4, 24'h007610};
        vt[3]  = '{6'h00, 6'h22, 1'b0, 4, 24'h007610};
        vt[4]  = '{6'h00, 6'h24, 1'b0, 4, 24'h007610};
        vt[5]  = '{6'h00, 6'h25, 1'b0, 4, 24'h007610};
        vt[6]  = '{6'h00, 6'h00, 1'b0, 4, 24'h007610};
        vt[7]  = '{6'h04, 6'h11, 1'b1, 3, 24'h000810};
        vt[8]  = '{6'h04, 6'h11, 1'b0, 3, 24'h000810};
        vt[9]  = '{6'h08, 6'h3C, 1'b0, 4, 24'h00A910};
        vt[10] = '{6'h3F, 6'h20, 1'b0, 2, 24'h000010};
        vt[11] = '{6'h00, 6'h01, 1'b0, 2, 24'h000010};
        vt[12] = '{6'h2B, 6'h07, 1'b0, 4, 24'h005210};
        vt[13] = '{6'h02, 6'h2A, 1'b1, 3, 24'h000B10};

        rst = 1'b0; opcode = 6'h23; funct = '0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset outs", 32'(act), 32'(rst_out()));
        rst = 1'b1;

        for (int i = 0; i < 14; i++)
            run_instr(vt[i].op, vt[i].fn, vt[i].z,
                      vt[i].len, vt[i].seq, 0);

        // Reset asserted while lw sits in MEMRD.
        run_instr(6'h23, 6'h00, 1'b0, 5, 24'h043210, 4);
        rst = 1'b0;
        #1;
        chk("rst in memrd state", 32'(state), 32'd3);
        chk("rst in memrd mem_read", 32'(mem_read), 32'd0);
        chk("rst in memrd outs", 32'(act), 32'(rst_out()));
        @(negedge clk);
        #1;
        chk("rst after edge state", 32'(state), 32'd0);
        chk("rst after edge outs", 32'(act), 32'(rst_out()));
        rst = 1'b1;
        run_instr(6'h2B, 6'h00, 1'b0, 4, 24'h005210, 0);

        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        for (int n = 0; n < 60; n++) begin
            fn = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 7))
                0: op = 6'h23;
                1: op = 6'h2B;
                2: begin op = 6'h00; fn = fl[$urandom_range(0, 5)]; end
                3: op = 6'h04;
                4: op = 6'h08;
                5: op = 6'h02;
                6: begin
                    do op = 6'($urandom_range(1, 63));
                    while (legal(op, fn));
                end
                default: begin
                    op = 6'h00;
                    while (legal_fn(fn)) fn = 6'($urandom_range(0, 63));
                end
            endcase
            model(op, fn, len, seq);
            run_instr(op, fn, 1'($urandom_range(0, 1)), len, seq, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Port clk, input, 1: single clock; all state changes SHALL occur on its rising edge.
REQ-002 Port rst, input, 1: reset SHALL be synchronous and active-low; one clock, no other clock or reset.
REQ-003 Port opcode, input, 6: instruction bits [31:26], valid from DECODE onward.
REQ-004 Port funct, input, 6: instruction bits [5:0], valid from DECODE onward.
REQ-005 Port zero, input, 1: ALU zero flag for the current cycle's operation.
REQ-006 Port alu_ctl, output, 3: ALU operation; add 010, sub 110, and 000, or 001, slt 111, sll 011.
REQ-007 Port alu_src_a, output, 1: ALU A select; 0 = PC, 1 = register A.
REQ-008 Port alu_src_b, output, 2: ALU B select; 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-009 Port pc_src, output, 2: next-PC select; 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-010 Ports pc_we, ir_we, reg_we, mem_read, mem_write, iord, reg_dst, mem_to_reg, output, 1 each: datapath strobes and selects.
REQ-011 Port illegal, output, 1: one-cycle pulse in DECODE for an unsupported opcode/funct.
REQ-012 Port state, output, 4: current state encoding, for debug.

Function
REQ-013 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Encodings 12-15 are unused.
REQ-014 Outputs SHALL be Moore-decoded from state only. The exception is pc_we in BRANCH (REQ-024). Any output not listed for a state SHALL be 0.
REQ-015 FETCH outputs: mem_read=1, iord=0, ir_we=1, alu_src_a=0, alu_src_b=01, alu_ctl=010, pc_src=00, pc_we=1. Next state is DECODE.
REQ-016 DECODE outputs: alu_src_a=0, alu_src_b=11, alu_ctl=010.
- Next state: lw 0x23 / sw 0x2B -> MEMADR; R-type 0x00 -> EXEC; beq 0x04 -> BRANCH; addi 0x08 -> ADDIEX; j 0x02 -> JUMP.
- Any other opcode -> FETCH with illegal=1.
REQ-017 R-type funct decode SHALL be: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x00 sll. Any other funct with opcode 0x00 SHALL be treated as illegal in DECODE (-> FETCH, illegal=1).
REQ-018 MEMADR outputs: alu_src_a=1, alu_src_b=10, alu_ctl=010. Next state: lw -> MEMRD, sw -> MEMWR.
REQ-019 MEMRD outputs: mem_read=1, iord=1. Next state is MEMWB.
REQ-020 MEMWB outputs: reg_we=1, reg_dst=0, mem_to_reg=1. Next state is FETCH.
REQ-021 MEMWR outputs: mem_write=1, iord=1. Next state is FETCH.
REQ-022 EXEC outputs: alu_src_a=1, alu_src_b=00, alu_ctl from funct per REQ-017. Next state is ALUWB. Routing of shamt for sll is the datapath's responsibility.
REQ-023 ALUWB outputs: reg_we=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
REQ-024 BRANCH outputs: alu_src_a=1, alu_src_b=00, alu_ctl=110, pc_src=01, pc_we=zero (same-cycle combinational). Next state is FETCH.
REQ-025 ADDIEX outputs: alu_src_a=1, alu_src_b=10, alu_ctl=010. Next state is ADDIWB.
REQ-026 ADDIWB outputs: reg_we=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
REQ-027 JUMP outputs: pc_src=10, pc_we=1. Next state is FETCH.
REQ-028 Latency in cycles including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-029 opcode and funct SHALL be sampled combinationally in DECODE, MEMADR and EXEC only. The datapath holds IR stable from DECODE until the next FETCH.
REQ-030 The unused encodings 12-15 SHALL transition to FETCH on the next clock, with all outputs 0 in that cycle.

Reset
REQ-031 While rst=0 at a rising edge, state SHALL load FETCH, regardless of the current state (including mid-instruction).
REQ-032 While rst=0, pc_we, ir_we, reg_we, mem_read, mem_write and illegal SHALL be forced to 0. The remaining outputs SHALL take their FETCH values, and state SHALL read 0 after the edge.
REQ-033 The first clock edge with rst=1 SHALL execute FETCH, with pc_we=1 and ir_we=1 asserted in that cycle.

Verification
REQ-034 Reset, then opcode 0x23: the bench SHALL see states 0,1,2,3,4,0; reg_we=1 and mem_to_reg=1 only in state 4; mem_read=1 in states 0 and 3.
REQ-035 R-type with funct 0x2A: the bench SHALL see states 0,1,6,7,0; alu_ctl=111 in state 6; reg_we=1 and reg_dst=1 in state 7.
REQ-036 beq with zero=1, then beq with zero=0: pc_we in state 8 SHALL be 1, then 0; alu_ctl=110 and pc_src=01 in both.
REQ-037 opcode 0x3F, and separately R-type with funct 0x01: illegal=1 for exactly one cycle in state 1; next state 0; no reg_we or mem_write at any point.
REQ-038 rst driven low while in state 3 (lw MEMRD): the next state SHALL be 0, with mem_read=0 while rst is low; release SHALL restart cleanly at FETCH.
REQ-039 sw then j back-to-back: the bench SHALL see states 0,1,2,5,0,1,11,0; mem_write=1 only in state 5; pc_src=10 and pc_we=1 in state 11.
